// File: rtl/race_sequencer.sv
// race_sequencer: game-level sequencer for the road datapath (ticks, lives, crash recovery, game over).
// Optional pause support is compiled in when RACE_SEQUENCER_PAUSE_EN is defined.
module race_sequencer #(
    parameter int SCROLL_DIV  = 131072,
    parameter int DROP_DIV    = 33000000,
    parameter int SCORE_DIV   = 50000000,
    parameter int LIVES       = 3,
    parameter int CRASH_TICKS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef RACE_SEQUENCER_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       colision,
    output logic       scroll_tick,
    output logic       drop,
    output logic       alive,
    output logic       clear_road,
    output logic       flash,
    output logic [2:0] lives,
    output logic [5:0] score,
    output logic       game_over
);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam int DW = $clog2(DROP_DIV);
    localparam int OW = $clog2(SCORE_DIV);
    localparam int CW = $clog2(CRASH_TICKS) < 3 ? 3 : $clog2(CRASH_TICKS);
    localparam logic [SW-1:0] SCROLL_MAX = SW'(SCROLL_DIV - 1);
    localparam logic [DW-1:0] DROP_MAX   = DW'(DROP_DIV - 1);
    localparam logic [OW-1:0] SCORE_MAX  = OW'(SCORE_DIV - 1);
    localparam logic [CW-1:0] CRASH_MAX  = CW'(CRASH_TICKS - 1);
    localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

`ifdef RACE_SEQUENCER_PAUSE_EN
    typedef enum logic [2:0] {IDLE, RUN, CRASH, OVER, PAUSE} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, CRASH, OVER} state_t;
`endif

    state_t        state;
    logic [SW-1:0] scroll_cnt;
    logic [DW-1:0] drop_cnt;
    logic [OW-1:0] score_cnt;
    logic [CW-1:0] crash_cnt;
    logic          start_q;
    logic          scroll_raw;
    logic          drop_raw;
    logic          score_raw;
    logic          start_rise;
    logic          can_start;
    logic          div_run;

    assign scroll_raw = scroll_cnt == SCROLL_MAX;
    assign drop_raw   = drop_cnt == DROP_MAX;
    assign score_raw  = score_cnt == SCORE_MAX;
    assign start_rise = start & ~start_q;

`ifdef RACE_SEQUENCER_PAUSE_EN
    logic pause_q;
    logic pause_rise;
    assign pause_rise = pause & ~pause_q;
    assign div_run    = state != PAUSE;
    assign can_start  = state == IDLE || state == OVER || state == PAUSE;

    // Pause edge detector
    always_ff @(posedge clk) begin
        pause_q <= reset ? 1'b0 : pause;
    end
`else
    assign div_run   = 1'b1;
    assign can_start = state == IDLE || state == OVER;
`endif

    // Free-running tick dividers; they only stand still while paused
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_cnt <= '0;
            drop_cnt   <= '0;
            score_cnt  <= '0;
        end else if (div_run) begin
            scroll_cnt <= scroll_raw ? '0 : scroll_cnt + 1'b1;
            drop_cnt   <= drop_raw ? '0 : drop_cnt + 1'b1;
            score_cnt  <= score_raw ? '0 : score_cnt + 1'b1;
        end
    end

    // Game state machine with registered pulses and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            crash_cnt   <= '0;
            lives       <= LIVES_INIT;
            score       <= '0;
            flash       <= 1'b0;
            scroll_tick <= 1'b0;
            drop        <= 1'b0;
            clear_road  <= 1'b0;
            alive       <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_q     <= start;
            scroll_tick <= scroll_raw && (state == RUN || state == CRASH);
            drop        <= 1'b0;
            clear_road  <= 1'b0;
            if (start_rise && can_start) begin
                state      <= RUN;
                alive      <= 1'b1;
                game_over  <= 1'b0;
                lives      <= LIVES_INIT;
                score      <= '0;
                flash      <= 1'b0;
                clear_road <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (colision) begin
                            state     <= CRASH;
                            alive     <= 1'b0;
                            lives     <= lives - 1'b1;
                            flash     <= 1'b1;
                            crash_cnt <= '0;
                        end
`ifdef RACE_SEQUENCER_PAUSE_EN
                        else if (pause_rise) begin
                            state <= PAUSE;
                            alive <= 1'b0;
                        end
`endif
                        else begin
                            drop <= drop_raw;
                            if (score_raw && score != 6'd63) score <= score + 1'b1;
                        end
                    end
                    CRASH: begin
                        if (scroll_raw) begin
                            if (crash_cnt == CRASH_MAX) begin
                                state      <= lives == 3'd0 ? OVER : RUN;
                                alive      <= lives != 3'd0;
                                game_over  <= lives == 3'd0;
                                clear_road <= lives != 3'd0;
                                flash      <= lives == 3'd0;
                            end else begin
                                crash_cnt <= crash_cnt + 1'b1;
                                if (crash_cnt[2:0] == 3'd7) flash <= ~flash;
                            end
                        end
                    end
`ifdef RACE_SEQUENCER_PAUSE_EN
                    PAUSE: begin
                        if (pause_rise) begin
                            state <= RUN;
                            alive <= 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_race_sequencer.sv
// tb_race_sequencer: scoreboard bench for race_sequencer with small divider parameters.
module tb_race_sequencer;
    localparam int SD = 4;
    localparam int DD = 7;
    localparam int OD = 10;
    localparam int L  = 3;
    localparam int CT = 16;

    logic       clk = 0;
    logic       reset = 1;
    logic       start = 0;
    logic       colision = 0;
    logic       pause = 0;
    logic       scroll_tick, drop, alive, clear_road, flash, game_over;
    logic [2:0] lives;
    logic [5:0] score;

    int errors = 0;
    int checks = 0;
    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];
    logic [14:0] e, o;

    int m_st, m_sc, m_dc, m_oc, m_cc, m_lives, m_score;
    bit m_flash, m_sq, m_pq, m_scroll, m_drop, m_clear;

    race_sequencer #(
        .SCROLL_DIV(SD), .DROP_DIV(DD), .SCORE_DIV(OD), .LIVES(L), .CRASH_TICKS(CT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef RACE_SEQUENCER_PAUSE_EN
        .pause(pause),
`endif
        .colision(colision),
        .scroll_tick(scroll_tick),
        .drop(drop),
        .alive(alive),
        .clear_road(clear_road),
        .flash(flash),
        .lives(lives),
        .score(score),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference model: states 0 idle, 1 run, 2 crash, 3 over, 4 pause
    task automatic model();
        bit rs, rd, ro, rise, prise, frozen;
        if (reset) begin
            m_st = 0; m_sc = 0; m_dc = 0; m_oc = 0; m_cc = 0; m_lives = L; m_score = 0;
            m_flash = 0; m_sq = 0; m_pq = 0; m_scroll = 0; m_drop = 0; m_clear = 0;
            return;
        end
        rs = m_sc == SD - 1;
        rd = m_dc == DD - 1;
        ro = m_oc == OD - 1;
        rise = start && !m_sq;
        prise = pause && !m_pq;
        m_sq = start;
        m_pq = pause;
        frozen = m_st == 4;
        m_scroll = rs && (m_st == 1 || m_st == 2);
        m_drop = 0;
        m_clear = 0;
        if (rise && (m_st == 0 || m_st == 3 || m_st == 4)) begin
            m_st = 1; m_lives = L; m_score = 0; m_clear = 1; m_flash = 0;
        end else if (m_st == 1) begin
            if (colision) begin
                m_st = 2; m_lives--; m_flash = 1; m_cc = 0;
            end else if (prise) begin
                m_st = 4;
            end else begin
                m_drop = rd;
                if (ro && m_score < 63) m_score++;
            end
        end else if (m_st == 2 && rs) begin
            if (m_cc == CT - 1) begin
                if (m_lives == 0) begin
                    m_st = 3; m_flash = 1;
                end else begin
                    m_st = 1; m_clear = 1; m_flash = 0;
                end
            end else begin
                if (m_cc % 8 == 7) m_flash = !m_flash;
                m_cc++;
            end
        end else if (m_st == 4 && prise) begin
            m_st = 1;
        end
        if (!frozen) begin
            m_sc = (m_sc + 1) % SD;
            m_dc = (m_dc + 1) % DD;
            m_oc = (m_oc + 1) % OD;
        end
    endtask

    function automatic logic [14:0] obsv();
        return {scroll_tick, drop, alive, clear_road, flash, lives, score, game_over};
    endfunction

    // One clock: advance the model, queue its prediction, then sample the DUT
    task automatic step();
        @(posedge clk);
        model();
        exp_q.push_back({m_scroll, m_drop, m_st == 1, m_clear, m_flash, 3'(m_lives), 6'(m_score), m_st == 3});
        #1;
        obs_q.push_back(obsv());
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        step();
        reset = 0;
        checks++;
        if ({scroll_tick, drop, alive, clear_road, flash, game_over} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {scroll_tick, drop, alive, clear_road, flash, game_over});
        end
        checks++;
        if (lives !== 3'd3 || score !== 6'd0) begin
            errors++;
            $display("FAIL reset_counts: lives=%0d score=%0d expected 3 and 0", lives, score);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_reset: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_start();
        int n = 0;
        start = 1;
        step();
        start = 0;
        checks++;
        if (clear_road !== 1'b1 || alive !== 1'b1 || lives !== 3'd3 || score !== 6'd0) begin
            errors++;
            $display("FAIL start: clear=%b alive=%b lives=%0d score=%0d expected 1 1 3 0", clear_road, alive, lives, score);
        end
        repeat (16) begin
            step();
            n += int'(scroll_tick);
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL scroll_rate: got %0d ticks expected 4", n); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_start: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_collision();
        int s0, n, g = 0;
        while (m_oc != OD - 1 && g < 20) begin step(); g++; end
        s0 = m_score;
        colision = 1;
        step();
        colision = 0;
        checks++;
        if (score !== 6'(s0) || lives !== 3'd2 || alive !== 1'b0 || flash !== 1'b1) begin
            errors++;
            $display("FAIL collide: score=%0d lives=%0d alive=%b flash=%b expected %0d 2 0 1", score, lives, alive, flash, s0);
        end
        n = 0;
        do begin step(); n++; end while (clear_road !== 1'b1 && n < 100);
        checks++;
        if (n < 61 || n > 64) begin errors++; $display("FAIL crash_len: got %0d cycles expected 61..64", n); end
        checks++;
        if (alive !== 1'b1 || flash !== 1'b0) begin
            errors++;
            $display("FAIL recover: alive=%b flash=%b expected 1 0", alive, flash);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_collision: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_saturate();
        int d = 0;
        repeat (630) step();
        repeat (70) begin step(); d += int'(drop); end
        checks++;
        if (score !== 6'd63) begin errors++; $display("FAIL saturate: score=%0d expected 63", score); end
        checks++;
        if (d != 10) begin errors++; $display("FAIL drop_rate: got %0d drops expected 10", d); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_saturate: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_game_over();
        int n;
        for (int k = 0; k < 2; k++) begin
            colision = 1;
            step();
            colision = 0;
            n = 0;
            do begin step(); n++; end while (clear_road !== 1'b1 && game_over !== 1'b1 && n < 100);
            checks++;
            if (n >= 100) begin errors++; $display("FAIL crash_timeout: round %0d got no exit expected exit", k); end
        end
        checks++;
        if (game_over !== 1'b1 || lives !== 3'd0 || flash !== 1'b1 || score !== 6'd63) begin
            errors++;
            $display("FAIL over: go=%b lives=%0d flash=%b score=%0d expected 1 0 1 63", game_over, lives, flash, score);
        end
        repeat (30) step();
        checks++;
        if (game_over !== 1'b1 || score !== 6'd63 || alive !== 1'b0) begin
            errors++;
            $display("FAIL over_hold: go=%b score=%0d alive=%b expected 1 63 0", game_over, score, alive);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_game_over: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_start_held();
        int c = 0;
        start = 1;
        step();
        c += int'(clear_road);
        checks++;
        if (lives !== 3'd3 || score !== 6'd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart: lives=%0d score=%0d go=%b expected 3 0 0", lives, score, game_over);
        end
        repeat (39) begin step(); c += int'(clear_road); end
        start = 0;
        step();
        checks++;
        if (c != 1) begin errors++; $display("FAIL start_held: got %0d clears expected 1", c); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_start_held: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_reset_mid_crash();
        int n = 0;
        colision = 1;
        step();
        colision = 0;
        repeat (10) step();
        checks++;
        if (alive !== 1'b0 || flash !== 1'b1) begin
            errors++;
            $display("FAIL in_crash: alive=%b flash=%b expected 0 1", alive, flash);
        end
        reset = 1;
        step();
        reset = 0;
        checks++;
        if (obsv() !== {5'b0, 3'd3, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", obsv(), {5'b0, 3'd3, 6'd0, 1'b0});
        end
        repeat (8) begin step(); n += int'(scroll_tick | alive); end
        checks++;
        if (n != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles expected 0", n); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_reset_mid: got %h expected %h", o, e); end
        end
    endtask

`ifdef RACE_SEQUENCER_PAUSE_EN
    task automatic test_pause();
        int s0, n = 0;
        start = 1;
        step();
        start = 0;
        repeat (15) step();
        pause = 1;
        step();
        pause = 0;
        s0 = m_score;
        repeat (30) begin step(); n += int'(scroll_tick | drop | alive); end
        checks++;
        if (n != 0 || score !== 6'(s0)) begin
            errors++;
            $display("FAIL paused: active=%0d score=%0d expected 0 %0d", n, score, s0);
        end
        pause = 1;
        step();
        pause = 0;
        checks++;
        if (alive !== 1'b1) begin errors++; $display("FAIL resume: alive=%b expected 1", alive); end
        repeat (20) step();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL sb_pause: got %h expected %h", o, e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_collision();
        test_saturate();
        test_game_over();
        test_start_held();
        test_reset_mid_crash();
`ifdef RACE_SEQUENCER_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
- Game-level controller that sequences the road datapath (scroll/obstacle engine plus collision detector).
- Generates the scroll tick, obstacle-drop pulse and score tick, and gates them by game state.
- Manages lives, the crash-recovery interval with a flash signal, and game-over.
- Sits between the top-level input synchronisers and the road datapath; the datapath returns a level `colision` flag.

Parameters:
- SCROLL_DIV, 131072, clock cycles per scroll tick (≥2).
- DROP_DIV, 33000000, clock cycles per obstacle-drop pulse (≥2).
- SCORE_DIV, 50000000, clock cycles per score increment (≥2).
- LIVES, 3, lives loaded at game start (1..7).
- CRASH_TICKS, 64, scroll ticks spent in CRASH before resuming (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  debounced start request, level; rising edge detected internally.
- colision  in  1  collision flag from the road datapath, level.
- scroll_tick  out  1  one-cycle pulse; advances road and player.
- drop  out  1  one-cycle pulse; spawns an obstacle.
- alive  out  1  high in RUN; datapath accepts steering only when high.
- clear_road  out  1  one-cycle pulse; datapath removes all obstacles.
- flash  out  1  crash flash for red overlay.
- lives  out  3  remaining lives.
- score  out  6  score, saturating.
- game_over  out  1  high in OVER.

Behaviour:
- Reset: state=IDLE; all dividers=0; lives=LIVES; score=0; flash=0; every pulse output=0; game_over=0; start edge register=0.
- States: IDLE, RUN, CRASH, OVER (2-bit encoding).
- Dividers:
  - Three free-running counters run in every state; each wraps from DIV-1 to 0.
  - The raw tick fires on the cycle the counter holds DIV-1.
  - All outputs are registered: a raw tick on cycle N appears on the output at N+1.
- Output gating:
  - scroll_tick is output in RUN and CRASH.
  - drop and the score increment are active only in RUN.
- start_rise = start & ~start_q.
- IDLE:
  - On start_rise, go to RUN.
  - Load lives=LIVES, clear score, pulse clear_road for one cycle (same cycle the state becomes RUN).
- RUN:
  - alive=1.
  - On a score tick, score increments, saturating at 63.
  - If colision=1, go to CRASH next cycle. colision has priority over a same-cycle score tick or drop: neither is issued that cycle.
  - lives decrements on the transition into CRASH.
- CRASH:
  - alive=0.
  - A crash counter counts scroll ticks from 0.
  - flash toggles on every 8th scroll tick (crash count[2:0]==7); flash starts at 1 on entry.
  - When the count reaches CRASH_TICKS-1 and a scroll tick occurs:
    - If lives==0, go to OVER.
    - Otherwise go to RUN, pulse clear_road, and set flash=0.
  - colision is ignored in CRASH.
- OVER:
  - game_over=1, flash=1 steady, score is held.
  - On start_rise, behave exactly as IDLE+start: go to RUN, reload lives, clear score, pulse clear_road.
- start held high issues only one start_rise; it must drop low and rise again before it acts again.
- Reset asserted mid-game has priority over everything and returns all state to reset values on the next edge.
- lives never underflows: a decrement happens only in RUN, and RUN is entered only with lives≥1.

Optional Feature:
- Macro: RACE_SEQUENCER_PAUSE_EN.
- When defined:
  - Adds input pause (1 bit, level) and state PAUSE.
  - A pause rising edge in RUN enters PAUSE; the next pause rising edge returns to RUN.
  - In PAUSE: alive=0; scroll_tick, drop and score are frozen; all three divider counters hold their values; colision is ignored.
  - Reset or start_rise in PAUSE behaves like the reset and OVER paths respectively.
- When undefined: no pause port, no PAUSE state; behaviour is exactly as above.

Test Plan:
- Reset, then start pulse → clear_road one cycle high, state RUN, alive=1, lives=3, score=0. With SCROLL_DIV=4, scroll_tick is high every 4th cycle.
- SCORE_DIV=10, run 700 cycles with colision=0 → score reaches 63 and stays 63; drop pulses appear at DROP_DIV period.
- colision asserted on the same cycle as a score tick in RUN → score unchanged, lives 3→2, alive=0 next cycle, flash=1.
- CRASH_TICKS=16, SCROLL_DIV=4 → flash toggles every 32 cycles; after 64 cycles in CRASH: clear_road pulse, state RUN, flash=0.
- Three collisions → after the third CRASH interval game_over=1, lives=0, score held. start held high → one restart only: lives=3, score=0.
- Reset asserted mid-CRASH → all outputs at reset values next cycle, state IDLE. With pause enabled: pause in RUN freezes score and dividers; a second pause edge resumes with the counters unchanged.
